// File: rtl/hp_pkg.sv
// hp_pkg: shared opcodes, flag layout, controller state and widths for the
// half-precision request controller (hp_req_ctrl) and its request FIFO.
// No ports; imported by hp_req_fifo and hp_req_ctrl.
package hp_pkg;

  // Opcode encoding: bit0 = SR (stochastic rounding), bits[2:1] = operation.
  localparam logic [2:0] ADD_RN = 3'b000;
  localparam logic [2:0] ADD_SR = 3'b001;
  localparam logic [2:0] SUB_RN = 3'b010;
  localparam logic [2:0] SUB_SR = 3'b011;
  localparam logic [2:0] MUL_RN = 3'b100;
  localparam logic [2:0] MUL_SR = 3'b101;
  localparam logic [2:0] DIV_RN = 3'b110;
  localparam logic [2:0] DIV_SR = 3'b111;

  // FPU class flag bit positions.
  localparam int FLAG_ZERO = 5;
  localparam int FLAG_INF  = 4;
  localparam int FLAG_SUBN = 3;
  localparam int FLAG_NORM = 2;
  localparam int FLAG_QNAN = 1;
  localparam int FLAG_SNAN = 0;

  typedef struct packed {
    logic zero;
    logic inf;
    logic subn;
    logic norm;
    logic qnan;
    logic snan;
  } hp_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } hp_ctrl_state_t;

  localparam int OPND_W = 16;
  localparam int OP_W   = 3;
  localparam int TAG_W  = 4;
  localparam int REQ_W  = OPND_W + OPND_W + OP_W + TAG_W;  // 39
  localparam int CNT_W  = 3;

endpackage

// File: rtl/hp_req_fifo.sv
// hp_req_fifo: synchronous request queue, WIDTH bits x DEPTH entries (DEPTH power of two).
// Ports: clk, rst (async, active-high), i_push/i_dat, i_pop, o_full, o_empty, o_head.
// Push while full and pop while empty are ignored; head is valid whenever !o_empty.
module hp_req_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/hp_req_ctrl.sv
// hp_req_ctrl: queues core requests, holds operands on the FPU for FPU_LAT cycles,
// captures result/flags and returns them in order. Ports: req_* (core in, valid/ready),
// fpu_* (to/from FPU), rsp_* (core out, valid/ready), busy, fflags/fflags_clr. Macro HP_STICKY_FLAGS_EN.
module hp_req_ctrl
  import hp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FPU_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [2:0]  req_op,
  input  logic [3:0]  req_tag,
  output logic [15:0] fpu_src_a,
  output logic [15:0] fpu_src_b,
  output logic [2:0]  fpu_operation,
  output logic        fpu_ops_ready,
  input  logic [15:0] fpu_res,
  input  logic [5:0]  fpu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_res,
  output logic [5:0]  rsp_flags,
  output logic [3:0]  rsp_tag,
  output logic        busy,
  output logic [5:0]  fflags,
  input  logic        fflags_clr
);

  hp_ctrl_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_src_a;
  logic [15:0]      r_src_b;
  logic [2:0]       r_op;
  logic [3:0]       r_tag;
  logic             r_ops_rdy;
  logic             r_rsp_vld;
  logic [15:0]      r_rsp_res;
  hp_flags_t        r_rsp_flags;
  logic [3:0]       r_rsp_tag;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_rsp_hs;
  logic [REQ_W-1:0] w_head;

  assign req_ready = !w_full;
  assign w_rsp_hs  = r_rsp_vld && rsp_ready;
  // Pop straight into EXEC from IDLE, or from RESP on the handshake edge.
  assign w_pop     = !w_empty &&
                     ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));

  hp_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (req_valid),
    .i_dat   ({req_a, req_b, req_op, req_tag}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_op        <= '0;
      r_tag       <= '0;
      r_ops_rdy   <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_flags <= '0;
      r_rsp_tag   <= '0;
    end else if (w_pop) begin
      {r_src_a, r_src_b, r_op, r_tag} <= w_head;
      r_cnt     <= CNT_W'(FPU_LAT - 1);
      r_ops_rdy <= 1'b1;
      r_rsp_vld <= 1'b0;
      r_state   <= ST_EXEC;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_rsp_res   <= fpu_res;
            r_rsp_flags <= fpu_flags;
            r_rsp_tag   <= r_tag;
            r_rsp_vld   <= 1'b1;
            r_ops_rdy   <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // Non-empty case is handled by the pop branch above.
          if (rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fpu_src_a     = r_src_a;
  assign fpu_src_b     = r_src_b;
  assign fpu_operation = r_op;
  assign fpu_ops_ready = r_ops_rdy;
  assign rsp_valid     = r_rsp_vld;
  assign rsp_res       = r_rsp_res;
  assign rsp_flags     = r_rsp_flags;
  assign rsp_tag       = r_rsp_tag;
  assign busy          = (r_state != ST_IDLE) || !w_empty;

`ifdef HP_STICKY_FLAGS_EN
  hp_flags_t r_fflags;

  // A clear on the handshake edge wipes old flags but keeps the new response's.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fflags <= '0;
    end else if (fflags_clr) begin
      r_fflags <= w_rsp_hs ? r_rsp_flags : hp_flags_t'('0);
    end else if (w_rsp_hs) begin
      r_fflags <= r_fflags | r_rsp_flags;
    end
  end

  assign fflags = r_fflags;
`else
  logic w_unused_sticky;
  assign w_unused_sticky = fflags_clr ^ w_rsp_hs;
  assign fflags          = '0;
`endif

endmodule

// File: tb/tb_hp_req_ctrl.sv
// tb_hp_req_ctrl: directed bench for hp_req_ctrl; one instance with FPU_LAT=1, one with FPU_LAT=3.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_hp_req_ctrl;

`ifdef HP_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with FPU_LAT = 1
  logic        rst, req_valid, req_ready, fpu_ops_ready, rsp_valid, rsp_ready, busy, fflags_clr;
  logic [15:0] req_a, req_b, fpu_src_a, fpu_src_b, fpu_res, rsp_res;
  logic [2:0]  req_op, fpu_operation;
  logic [3:0]  req_tag, rsp_tag;
  logic [5:0]  fpu_flags, rsp_flags, fflags;
  logic        model_mode;
  logic [15:0] fix_res;
  logic [5:0]  fix_flags;

  // FPU model: fixed values, or res = src_a + 1 and flags = src_b[5:0].
  assign fpu_res   = model_mode ? (fpu_src_a + 16'd1) : fix_res;
  assign fpu_flags = model_mode ? fpu_src_b[5:0] : fix_flags;

  hp_req_ctrl #(.FIFO_DEPTH(4), .FPU_LAT(1)) u_dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .fpu_src_a(fpu_src_a), .fpu_src_b(fpu_src_b), .fpu_operation(fpu_operation),
    .fpu_ops_ready(fpu_ops_ready), .fpu_res(fpu_res), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy), .fflags(fflags),
    .fflags_clr(fflags_clr)
  );

  // Instance with FPU_LAT = 3
  logic        l3_rst, l3_req_valid, l3_req_ready, l3_ops_ready, l3_rsp_valid, l3_rsp_ready, l3_busy;
  logic [15:0] l3_req_a, l3_req_b, l3_src_a, l3_src_b, l3_rsp_res;
  logic [2:0]  l3_req_op, l3_op;
  logic [3:0]  l3_req_tag, l3_rsp_tag;
  logic [5:0]  l3_rsp_flags, l3_fflags;

  hp_req_ctrl #(.FIFO_DEPTH(4), .FPU_LAT(3)) u_dut3 (
    .clk(clk), .reset(l3_rst), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_a(l3_req_a), .req_b(l3_req_b), .req_op(l3_req_op), .req_tag(l3_req_tag),
    .fpu_src_a(l3_src_a), .fpu_src_b(l3_src_b), .fpu_operation(l3_op),
    .fpu_ops_ready(l3_ops_ready), .fpu_res(16'h0000), .fpu_flags(6'b000000),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_res(l3_rsp_res),
    .rsp_flags(l3_rsp_flags), .rsp_tag(l3_rsp_tag), .busy(l3_busy), .fflags(l3_fflags),
    .fflags_clr(1'b0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Run-length monitor for fpu_ops_ready on the FPU_LAT=3 instance.
  logic        mon3;
  int          cur_len, n_runs;
  int          run_len [4];
  logic [15:0] run_a   [4];
  logic [15:0] hold_a, hold_b;
  logic [2:0]  hold_op;
  logic        unstable;

  always @(negedge clk) begin
    if (mon3) begin
      if (l3_ops_ready) begin
        if (cur_len == 0) begin
          hold_a  = l3_src_a;
          hold_b  = l3_src_b;
          hold_op = l3_op;
        end else if (l3_src_a != hold_a || l3_src_b != hold_b || l3_op != hold_op) begin
          unstable = 1'b1;
        end
        cur_len++;
      end else if (cur_len != 0) begin
        if (n_runs < 4) begin
          run_len[n_runs] = cur_len;
          run_a[n_runs]   = hold_a;
        end
        n_runs++;
        cur_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  int          acc, nrsp, last_k;
  logic [15:0] s_res;
  logic [3:0]  s_tag;
  int          seen;

  initial begin
    rst = 1'b1; l3_rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    rsp_ready = 1'b0; fflags_clr = 1'b0;
    model_mode = 1'b0; fix_res = '0; fix_flags = '0;
    l3_req_valid = 1'b0; l3_req_a = '0; l3_req_b = '0; l3_req_op = '0; l3_req_tag = '0;
    l3_rsp_ready = 1'b0;
    mon3 = 1'b0; cur_len = 0; n_runs = 0; unstable = 1'b0;
    hold_a = '0; hold_b = '0; hold_op = '0;
    for (int i = 0; i < 4; i++) begin run_len[i] = 0; run_a[i] = '0; end

    repeat (2) @(negedge clk);
    // ---- reset values
    chk("rst_req_ready", req_ready, 1);
    chk("rst_src_a", fpu_src_a, 0);
    chk("rst_src_b", fpu_src_b, 0);
    chk("rst_op", fpu_operation, 0);
    chk("rst_ops_ready", fpu_ops_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fflags", fflags, 0);
    rst = 1'b0; l3_rst = 1'b0;
    @(negedge clk);

    // ---- single op: accepted at edge T
    fix_res = 16'h4000; fix_flags = 6'b000100;
    req_valid = 1'b1; req_a = 16'h3C00; req_b = 16'h4000; req_op = 3'b100; req_tag = 4'h5;
    @(negedge clk);                       // after T
    req_valid = 1'b0;
    chk("single_vld_T", rsp_valid, 0);
    chk("single_busy", busy, 1);
    @(negedge clk);                       // after T+1: EXEC
    chk("single_ops_ready", fpu_ops_ready, 1);
    chk("single_src_a", fpu_src_a, 16'h3C00);
    chk("single_src_b", fpu_src_b, 16'h4000);
    chk("single_op", fpu_operation, 3'b100);
    chk("single_vld_T1", rsp_valid, 0);
    @(negedge clk);                       // after T+2: capture, third cycle after accept
    chk("single_vld_T2", rsp_valid, 1);
    chk("single_res", rsp_res, 16'h4000);
    chk("single_flags", rsp_flags, 6'b000100);
    chk("single_tag", rsp_tag, 4'h5);
    chk("single_ops_low", fpu_ops_ready, 0);
    chk("single_src_held", fpu_src_a, 16'h3C00);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_vld_done", rsp_valid, 0);
    chk("single_idle", busy, 0);
    chk("single_fflags", fflags, STICKY ? 6'b000100 : 6'b000000);
    rsp_ready = 1'b0; fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    chk("clr_fflags", fflags, 0);

    // ---- fill / backpressure
    model_mode = 1'b1; acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_tag = 4'(i); req_a = 16'h1000 + 16'(i); req_b = 16'h0000;
      req_op = 3'(i);
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("fill_accepted", acc, 5);
    chk("fill_req_ready", req_ready, 0);
    chk("fill_rsp_valid", rsp_valid, 1);
    chk("fill_head_tag", rsp_tag, 0);
    chk("fill_head_res", rsp_res, 16'h1001);
    s_res = rsp_res; s_tag = rsp_tag;
    repeat (3) begin
      @(negedge clk);
      chk("stall_res", rsp_res, s_res);
      chk("stall_tag", rsp_tag, s_tag);
      chk("stall_vld", rsp_valid, 1);
    end
    rsp_ready = 1'b1; nrsp = 0; last_k = 0;
    for (int k = 0; k < 40 && nrsp < 5; k++) begin
      if (rsp_valid) begin
        chk("drain_tag", rsp_tag, 4'(nrsp));
        chk("drain_res", rsp_res, 16'h1001 + 16'(nrsp));
        if (nrsp > 0) chk("drain_spacing", k - last_k, 2);
        last_k = k;
        nrsp++;
      end
      @(negedge clk);
    end
    chk("drain_count", nrsp, 5);
    chk("drain_idle", busy, 0);
    chk("drain_req_ready", req_ready, 1);

    // ---- sticky flags accumulate
    req_valid = 1'b1; req_b = 16'h0002; req_tag = 4'hA;
    @(negedge clk);
    req_b = 16'h0010; req_tag = 4'hB;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("sticky_wait_idle", busy, 0);
    chk("sticky_or", fflags, STICKY ? 6'b010010 : 6'b000000);

    // ---- clear on the same edge as a handshake
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_b = 16'h0001; req_tag = 4'hC;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    chk("clrhs_rsp_valid", rsp_valid, 1);
    chk("clrhs_rsp_flags", rsp_flags, 6'b000001);
    rsp_ready = 1'b1; fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    chk("clrhs_fflags", fflags, STICKY ? 6'b000001 : 6'b000000);
    chk("clrhs_vld_done", rsp_valid, 0);

    // ---- FPU_LAT=3: operand hold length and stability
    l3_rsp_ready = 1'b1; mon3 = 1'b1;
    @(negedge clk);
    l3_req_valid = 1'b1; l3_req_a = 16'h1234; l3_req_b = 16'h5678; l3_req_op = 3'b011; l3_req_tag = 4'h7;
    @(negedge clk);
    l3_req_a = 16'h2222; l3_req_b = 16'h3333; l3_req_op = 3'b110; l3_req_tag = 4'h8;
    @(negedge clk);
    l3_req_valid = 1'b0;
    repeat (14) @(negedge clk);
    mon3 = 1'b0;
    chk("lat3_runs", n_runs, 2);
    chk("lat3_len0", run_len[0], 3);
    chk("lat3_len1", run_len[1], 3);
    chk("lat3_a0", run_a[0], 16'h1234);
    chk("lat3_a1", run_a[1], 16'h2222);
    chk("lat3_stable", unstable, 0);
    chk("lat3_idle", l3_busy, 0);

    // ---- reset mid-EXEC with two requests queued
    l3_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      l3_req_valid = 1'b1; l3_req_a = 16'h4000 + 16'(i); l3_req_tag = 4'(i);
      @(negedge clk);
    end
    l3_req_valid = 1'b0;
    chk("mid_exec_ops", l3_ops_ready, 1);
    chk("mid_exec_busy", l3_busy, 1);
    l3_rst = 1'b1;
    #1;
    chk("arst_req_ready", l3_req_ready, 1);
    chk("arst_busy", l3_busy, 0);
    chk("arst_ops_ready", l3_ops_ready, 0);
    chk("arst_rsp_valid", l3_rsp_valid, 0);
    chk("arst_src_a", l3_src_a, 0);
    chk("arst_src_b", l3_src_b, 0);
    chk("arst_op", l3_op, 0);
    chk("arst_rsp_res", l3_rsp_res, 0);
    chk("arst_rsp_tag", l3_rsp_tag, 0);
    chk("arst_rsp_flags", l3_rsp_flags, 0);
    chk("arst_fflags", l3_fflags, 0);
    @(negedge clk);
    l3_rst = 1'b0; l3_rsp_ready = 1'b1; seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (l3_rsp_valid || l3_busy || l3_ops_ready) seen++;
    end
    chk("arst_no_response", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hp_req_ctrl.md
# hp_req_ctrl

Sequencing front-end between the integer core and the half-precision FPU datapath (hp_top). It accepts operation requests from the core over a valid/ready channel and buffers them in a small FIFO. It drives each request's operands onto the FPU for a configured number of cycles, then captures the result and class flags. It returns them in order over a valid/ready response channel, so the core never has to hold operands stable itself.

## Interface
- FIFO_DEPTH, 4: request queue entries; power of two, ≥2.
- FPU_LAT, 1: cycles operands are held on the FPU before capture; 1..7.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  request slot free.
- req_a / req_b  in  16  operands.
- req_op  in  3  opcode: bit0 = SR, bits[2:1] = 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- req_tag  in  4  core-side identifier, returned unchanged.
- fpu_src_a / fpu_src_b  out  16  operands to FPU.
- fpu_operation  out  3  opcode to FPU.
- fpu_ops_ready  out  1  operands valid on FPU.
- fpu_res  in  16  FPU result.
- fpu_flags  in  6  FPU flags {zero, inf, subN, Norm, QNan, SNan}, bit5..bit0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts response.
- rsp_res  out  16, rsp_flags  out  6, rsp_tag  out  4  captured response.
- busy  out  1  state ≠ IDLE or FIFO non-empty.
- fflags  out  6  sticky flags (see Configuration).
- fflags_clr  in  1  clear sticky flags.

## Operation
- The clock is clk. reset is asynchronous and active-high; the polarity and synchronicity are fixed.
- **Request accept:** a request is pushed on a clock edge where req_valid && req_ready.
  - req_ready = !fifo_full.
  - There is no bypass. When the FIFO is full, a pop on the same edge does not allow a push.
- **FSM states:** IDLE, EXEC, RESP.
  - IDLE → EXEC when the FIFO is non-empty. The head is popped into the operand/op/tag registers and the hold counter is loaded with FPU_LAT−1.
  - EXEC: fpu_ops_ready = 1 and the counter decrements.
    - When the counter is 0 on an edge, fpu_res and fpu_flags are captured into the rsp_* registers and the state moves to RESP.
  - RESP: rsp_valid = 1 and fpu_ops_ready = 0.
    - On the rsp_ready edge, go to EXEC (popping the next request) if the FIFO is non-empty; otherwise go to IDLE.
- **Held signals:**
  - fpu_src_a/b and fpu_operation are registered and hold the last values outside EXEC.
  - rsp_res, rsp_flags and rsp_tag are stable while rsp_valid && !rsp_ready.
- **Forwarding and ordering:**
  - All 8 opcodes are forwarded unmodified. This block does not interpret results.
  - Responses are strictly in request order.
- **Reset:** reset at any point discards queued and in-flight requests. No response is emitted for them.

## Timing
- **Reset values:**
  - req_ready = 1.
  - fpu_src_a, fpu_src_b, fpu_operation = 0; fpu_ops_ready = 0.
  - rsp_valid = 0; rsp_res, rsp_flags, rsp_tag = 0.
  - busy = 0; fflags = 0; state = IDLE.
- **Latency:** a request accepted at edge T into an empty, idle block has the following timeline.
  - EXEC is entered at edge T+1.
  - Capture occurs at edge T+1+FPU_LAT.
  - rsp_valid is high in the cycle after that edge, so minimum accept-to-rsp_valid latency is FPU_LAT+2 cycles.
- **Throughput:** with rsp_ready held high, one response every FPU_LAT+1 cycles.
- **Capacity:** FIFO_DEPTH+1 requests can be accepted before req_ready falls (FIFO_DEPTH queued plus one in EXEC/RESP).
- **Counter width:** 3 bits, with no wrap beyond FPU_LAT−1.
- **Simultaneous push and pop on a non-empty FIFO:** both take effect and the count is unchanged.

## Configuration
- Macro: HP_STICKY_FLAGS_EN.
- **Defined:**
  - On each response handshake, fflags ← fflags | rsp_flags.
  - fflags_clr clears fflags on the next edge.
  - If fflags_clr and a handshake occur on the same edge, fflags ← rsp_flags (the clear applies first).
- **Undefined:** fflags is tied to 0 and fflags_clr is ignored. No sticky register is synthesised.

## Structure
- **Package hp_pkg:**
  - Opcode localparams ADD_RN..DIV_SR.
  - Flag bit index constants and packed type hp_flags_t (6 bits).
  - State enum hp_ctrl_state_t.
- **Sub-module hp_req_fifo:**
  - Parameterised width (16+16+3+4 = 39 bits) and depth.
  - Provides push, pop, full, empty and head data.
  - Registered read pointer, with async reset to empty.

## Test plan
- **Single op:** FPU_LAT=1; req a=16'h3C00, b=16'h4000, op=3'b100, tag=4'h5; FPU model returns 16'h4000, flags 6'b000100.
  - rsp_valid rises 3 cycles after the accept edge.
  - rsp_res=16'h4000, rsp_flags=6'b000100, rsp_tag=5.
- **Fill/backpressure:** FIFO_DEPTH=4, rsp_ready=0, tags 0..9 offered back-to-back.
  - Exactly 5 are accepted, then req_ready=0.
  - rsp_* stay stable while stalled.
  - After rsp_ready=1, responses arrive with tags 0,1,2,3,4 in order.
- **Latency sweep:** FPU_LAT=3; fpu_ops_ready is high for exactly 3 cycles per op, and fpu_src_* are constant during EXEC.
- **Reset mid-EXEC:** with 2 requests queued, assert reset during EXEC.
  - All outputs return to their reset values immediately, including req_ready=1 and busy=0.
  - No response follows.
- **Sticky flags, macro defined:**
  - Responses with flags 6'b000010 then 6'b010000 give fflags=6'b010010.
  - fflags_clr on the same edge as a handshake with flags 6'b000001 gives fflags=6'b000001.
- **Sticky flags, macro undefined:** the same stimulus leaves fflags=0.
